mips_fwd_hzd_unit: RTL and testbench
====================================

// Module: mips_fwd_hzd_unit
// PURPOSE
//  Parametrised operand-forwarding and load-use hazard unit for the MIPS pipeline; sits between ID/EX regs and ALU.
//  Resolves NUM_SRC E-stage source operands from M, W and a FWD_DEPTH-deep post-writeback history buffer.
//  Detects load-use hazards (load in M, consumer in E) and raises a one-cycle stall request.
//  Replaces the fixed 2-operand, M/W-only forwarding path; the load-use case is now stalled, not forwarded from M.
// PARAMETERS
//  NUM_SRC     2   number of E-stage source operands resolved in parallel (1..4)
//  FWD_DEPTH   1   retired-write history entries kept after W (0..4); covers regfile write/read skew
//  REG_ADDR_W  5   register address width
//  DATA_W      32  datapath width
//  SEL_W       $clog2(FWD_DEPTH+3)  width of each per-operand source select
// PORTS
//  clk           in   1                    clock
//  rst           in   1                    asynchronous reset, active-high
//  freeze_i      in   1                    whole-pipeline freeze (mem wait); history and FSM hold
//  src_addr_e    in   NUM_SRC*REG_ADDR_W   E-stage source register addresses, operand k at [k*REG_ADDR_W +: REG_ADDR_W]
//  rf_data_e     in   NUM_SRC*DATA_W       register-file read data for each operand
//  wr_en_m       in   1                    M-stage instruction writes a register
//  is_load_m     in   1                    M-stage instruction is LW
//  rd_m          in   REG_ADDR_W           M-stage destination
//  alu_res_m     in   DATA_W               M-stage ALU result
//  wr_en_w       in   1                    W-stage instruction writes a register
//  is_load_w     in   1                    W-stage instruction is LW
//  rd_w          in   REG_ADDR_W           W-stage destination
//  alu_res_w     in   DATA_W               W-stage ALU result
//  mem_rdata_w   in   DATA_W               load data, valid in W
//  op_data_e     out  NUM_SRC*DATA_W       resolved operands to ALU
//  fwd_sel_e     out  NUM_SRC*SEL_W        per-operand source: 0=RF 1=M 2=W 3+k=history k
//  stall_o       out  1                    load-use stall: hold IF/ID/EX, bubble into M
//  stall_cnt_o   out  32                   saturating load-use stall count (see CONFIGURATION)
//  fwd_cnt_o     out  32                   saturating count of cycles with any forwarded operand
// BEHAVIOUR
//  - Reset: history entries invalid; FSM=RUN; counters=0; stall_o=0; fwd_sel_e=0; op_data_e=rf_data_e.
//  - W result wb_w = is_load_w ? mem_rdata_w : alu_res_w.
//  - History: shift register; each non-frozen cycle entry0 <= {wr_en_w, rd_w, wb_w}, entry k <= entry k-1.
//    When freeze_i=1, history holds. FWD_DEPTH=0: no history storage, selects 3+ never produced.
//  - Per operand k, priority (first match wins), src_addr!=0 and writer valid:
//    M (wr_en_m & ~is_load_m & rd_m==src) > W (wr_en_w & rd_w==src) > history0 > ... > history[FWD_DEPTH-1] > RF.
//    A load in M never forwards; a match on it is a load-use hit for that operand.
//  - Register 0: never forwarded, never stalls; op = rf_data_e.
//  - lu_hit = any operand matches load in M (wr_en_m & is_load_m & rd_m==src, src!=0).
//    stall_o = lu_hit & ~freeze_i, combinational, same cycle. Pipeline inserts bubble; next cycle load is in W and forwards.
//  - During a load-use hit the operand mux still outputs the lower-priority match (ALU result is discarded).
//  - FSM RUN/STALL (Moore state, for counting and back-to-back tracking):
//    RUN -> STALL when stall_o; STALL -> STALL when stall_o again; STALL -> RUN otherwise; freeze_i holds state.
//  - Forwarding mux is purely combinational: zero-cycle latency from any input to op_data_e.
//  - Reset asserted mid-stall: stall_o drops with reset, history flushed, FSM=RUN immediately.
// CONFIGURATION
//  - Macro MIPS_FWD_PERF_CNT_EN defined: stall_cnt_o increments on each RUN->STALL or STALL->STALL cycle (stall_o=1),
//    fwd_cnt_o increments on each non-frozen cycle with any fwd_sel_e!=0; both saturate at 32'hFFFF_FFFF.
//  - Macro not defined: counter flops absent; stall_cnt_o and fwd_cnt_o tied to 32'h0.
// TESTING
//  1. M: ADD wr r3 alu_res_m=0x0000_0042; E src0=r3, rf=0 -> op0=0x42, fwd_sel0=1, stall_o=0.
//  2. M: LW r5; E src1=r5 -> stall_o=1 that cycle, FSM->STALL; next cycle W: LW r5 with
//     mem_rdata_w=0xDEAD_BEEF -> op1=0xDEADBEEF, sel1=2, stall_o=0, FSM->RUN; stall_cnt_o=1 (macro on).
//  3. W writes r7=0x11 at cycle t; at t+1 E src0=r7, rf_data stale 0 -> op0=0x11, sel0=3 (history0).
//  4. M writes r0 alu=5, W LW r0; E src0=r0, rf=0 -> op0=0, sel0=0, stall_o=0.
//  5. M writes r4=0xA, W writes r4=0xB, history0 r4=0xC; E src0=src1=r4 -> both ops=0xA, sel=1.
//  6. freeze_i=1 for 3 cycles with W writes -> history unchanged, stall_o=0; rst pulsed during STALL ->
//     stall_o=0, history invalid, counters=0, op_data_e=rf_data_e.

Source files
------------

// File: rtl/mips_fwd_hzd_unit.sv
// -----------------------------------------------------------------------------
// mips_fwd_hzd_unit
//
// Operand forwarding and load-use hazard unit between the ID/EX registers and
// the ALU. Each of NUM_SRC E-stage operands is resolved from the M-stage ALU
// result, the W-stage writeback value, a FWD_DEPTH-deep history of retired
// writes, or the register file, in that priority order. A load in M is never
// forwarded; a consumer of it in E raises a same-cycle stall request instead.
//
// Optional feature: define MIPS_FWD_PERF_CNT_EN to build the saturating
// stall / forward performance counters. Without it both counters read 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   freeze_i        whole-pipeline freeze; history and FSM hold
//   src_addr_e      E-stage source addresses, operand k at [k*REG_ADDR_W +: REG_ADDR_W]
//   rf_data_e       register-file read data per operand
//   wr_en_m, is_load_m, rd_m, alu_res_m              M-stage writer
//   wr_en_w, is_load_w, rd_w, alu_res_w, mem_rdata_w W-stage writer
//   op_data_e       resolved operands
//   fwd_sel_e       per-operand source: 0=RF 1=M 2=W 3+k=history k
//   stall_o         load-use stall request (combinational)
//   stall_cnt_o     saturating count of stall cycles
//   fwd_cnt_o       saturating count of unfrozen cycles with any forward
//
// FSM
//   state    | meaning
//   ST_RUN   | no load-use stall issued last unfrozen cycle
//   ST_STALL | stall issued last unfrozen cycle (back-to-back tracking)
// -----------------------------------------------------------------------------
module mips_fwd_hzd_unit #(
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 1,
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32,
   parameter int SEL_W      = $clog2(FWD_DEPTH + 3)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          freeze_i,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_e,
   input  logic [NUM_SRC*DATA_W-1:0]     rf_data_e,
   input  logic                          wr_en_m,
   input  logic                          is_load_m,
   input  logic [REG_ADDR_W-1:0]         rd_m,
   input  logic [DATA_W-1:0]             alu_res_m,
   input  logic                          wr_en_w,
   input  logic                          is_load_w,
   input  logic [REG_ADDR_W-1:0]         rd_w,
   input  logic [DATA_W-1:0]             alu_res_w,
   input  logic [DATA_W-1:0]             mem_rdata_w,
   output logic [NUM_SRC*DATA_W-1:0]     op_data_e,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_e,
   output logic                          stall_o,
   output logic [31:0]                   stall_cnt_o,
   output logic [31:0]                   fwd_cnt_o
);

   localparam int HD = (FWD_DEPTH > 0) ? FWD_DEPTH : 1;

   typedef enum logic {ST_RUN, ST_STALL} state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0]                 wb_w;
   logic                              lu_hit;
   logic [HD-1:0]                     hist_vld;
   logic [HD-1:0][REG_ADDR_W-1:0]     hist_rd;
   logic [HD-1:0][DATA_W-1:0]         hist_data;

   assign wb_w = is_load_w ? mem_rdata_w : alu_res_w;

   // Retired-write history: covers the skew between the regfile write in W
   // and the read that the E-stage instruction already performed in ID.
   generate
      if (FWD_DEPTH > 0) begin : g_hist
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hist_vld  <= '0;
               hist_rd   <= '0;
               hist_data <= '0;
            end else if (!freeze_i) begin
               hist_vld[0]  <= wr_en_w;
               hist_rd[0]   <= rd_w;
               hist_data[0] <= wb_w;
               for (int h = 1; h < FWD_DEPTH; h++) begin
                  hist_vld[h]  <= hist_vld[h-1];
                  hist_rd[h]   <= hist_rd[h-1];
                  hist_data[h] <= hist_data[h-1];
               end
            end
         end
      end else begin : g_no_hist
         assign hist_vld  = '0;
         assign hist_rd   = '0;
         assign hist_data = '0;
      end
   endgenerate

   // Forwarding mux. Reset forces the RF path so the outputs are defined
   // while the flops are held in reset.
   always_comb begin : p_fwd
      logic [REG_ADDR_W-1:0] src;
      logic                  hit;
      src       = '0;
      hit       = 1'b0;
      lu_hit    = 1'b0;
      op_data_e = rf_data_e;
      fwd_sel_e = '0;
      if (!rst) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            src = src_addr_e[k*REG_ADDR_W +: REG_ADDR_W];
            hit = 1'b0;
            if (src != '0) begin
               if (wr_en_m && is_load_m && (rd_m == src)) begin
                  lu_hit = 1'b1;
               end
               // A load in M is skipped here, so the lower-priority match
               // still drives the operand while the stall is in effect.
               if (wr_en_m && !is_load_m && (rd_m == src)) begin
                  hit = 1'b1;
                  fwd_sel_e[k*SEL_W +: SEL_W] = SEL_W'(1);
                  op_data_e[k*DATA_W +: DATA_W] = alu_res_m;
               end else if (wr_en_w && (rd_w == src)) begin
                  hit = 1'b1;
                  fwd_sel_e[k*SEL_W +: SEL_W] = SEL_W'(2);
                  op_data_e[k*DATA_W +: DATA_W] = wb_w;
               end
               for (int h = 0; h < FWD_DEPTH; h++) begin
                  if (!hit && hist_vld[h] && (hist_rd[h] == src)) begin
                     hit = 1'b1;
                     fwd_sel_e[k*SEL_W +: SEL_W] = SEL_W'(h + 3);
                     op_data_e[k*DATA_W +: DATA_W] = hist_data[h];
                  end
               end
            end
         end
      end
   end

   assign stall_o = lu_hit & ~freeze_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!freeze_i) begin
         state_d = stall_o ? ST_STALL : ST_RUN;
      end
   end

`ifdef MIPS_FWD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] fwd_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else if (!freeze_i) begin
         // Entering or staying in STALL is exactly a cycle with stall_o set.
         if ((state_d == ST_STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if ((|fwd_sel_e) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
   assign fwd_cnt_o   = 32'h0;
`endif

endmodule

// File: tb/tb_mips_fwd_hzd_unit.sv
module tb_mips_fwd_hzd_unit;

   localparam int NUM_SRC    = 2;
   localparam int FWD_DEPTH  = 1;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int SEL_W      = 2;

`ifdef MIPS_FWD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze_i;
   logic [4:0]  src0, src1;
   logic [31:0] rf0, rf1;
   logic        wr_en_m, is_load_m, wr_en_w, is_load_w;
   logic [4:0]  rd_m, rd_w;
   logic [31:0] alu_res_m, alu_res_w, mem_rdata_w;

   logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_e;
   logic [NUM_SRC*DATA_W-1:0]     rf_data_e;
   logic [NUM_SRC*DATA_W-1:0]     op_data_e;
   logic [NUM_SRC*SEL_W-1:0]      fwd_sel_e;
   logic                          stall_o;
   logic [31:0]                   stall_cnt_o, fwd_cnt_o;

   assign src_addr_e = {src1, src0};
   assign rf_data_e  = {rf1, rf0};

   int errors = 0;
   int checks = 0;
   int m_stall_cnt = 0;
   int m_fwd_cnt = 0;

   typedef struct {
      string       tag;
      logic [31:0] op0;
      logic [31:0] op1;
      logic [1:0]  sel0;
      logic [1:0]  sel1;
      logic        stall;
   } exp_t;

   exp_t sb[$];

   mips_fwd_hzd_unit #(
      .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH),
      .REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)
   ) dut (
      .clk(clk), .rst(rst), .freeze_i(freeze_i),
      .src_addr_e(src_addr_e), .rf_data_e(rf_data_e),
      .wr_en_m(wr_en_m), .is_load_m(is_load_m), .rd_m(rd_m), .alu_res_m(alu_res_m),
      .wr_en_w(wr_en_w), .is_load_w(is_load_w), .rd_w(rd_w), .alu_res_w(alu_res_w),
      .mem_rdata_w(mem_rdata_w),
      .op_data_e(op_data_e), .fwd_sel_e(fwd_sel_e), .stall_o(stall_o),
      .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      freeze_i    = 1'b0;
      src0 = '0; src1 = '0; rf0 = '0; rf1 = '0;
      wr_en_m = 1'b0; is_load_m = 1'b0; rd_m = '0; alu_res_m = '0;
      wr_en_w = 1'b0; is_load_w = 1'b0; rd_w = '0; alu_res_w = '0;
      mem_rdata_w = '0;
   endtask

   // Inputs are already applied; push the expectation, compare at the
   // falling edge, then advance past the next rising edge and step the
   // counter model for the cycle just completed.
   task automatic step(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                       input logic [1:0] s0, input logic [1:0] s1, input logic st);
      exp_t e;
      exp_t g;
      e.tag = tag; e.op0 = o0; e.op1 = o1; e.sel0 = s0; e.sel1 = s1; e.stall = st;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      chk({g.tag, ".op0"},   op_data_e[31:0],  g.op0);
      chk({g.tag, ".op1"},   op_data_e[63:32], g.op1);
      chk({g.tag, ".sel0"},  32'(fwd_sel_e[1:0]), 32'(g.sel0));
      chk({g.tag, ".sel1"},  32'(fwd_sel_e[3:2]), 32'(g.sel1));
      chk({g.tag, ".stall"}, 32'(stall_o), 32'(g.stall));
      chk({g.tag, ".stall_cnt"}, stall_cnt_o, (PERF && !rst) ? 32'(m_stall_cnt) : 32'h0);
      chk({g.tag, ".fwd_cnt"},   fwd_cnt_o,   (PERF && !rst) ? 32'(m_fwd_cnt)   : 32'h0);
      @(posedge clk);
      if (rst) begin
         m_stall_cnt = 0;
         m_fwd_cnt   = 0;
      end else if (!freeze_i) begin
         if (g.stall) m_stall_cnt++;
         if ((g.sel0 != 2'd0) || (g.sel1 != 2'd0)) m_fwd_cnt++;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // reset holds RF path even with a matching M writer
      wr_en_m = 1'b1; rd_m = 5'd3; alu_res_m = 32'h42; src0 = 5'd3; rf0 = 32'h99; rf1 = 32'h5;
      step("reset", 32'h99, 32'h5, 2'd0, 2'd0, 1'b0);
      rst = 1'b0;

      // forward ALU result from M
      idle(); wr_en_m = 1'b1; rd_m = 5'd3; alu_res_m = 32'h42; src0 = 5'd3; rf1 = 32'h1234;
      step("m_fwd", 32'h42, 32'h1234, 2'd1, 2'd0, 1'b0);

      // load-use: stall, then forward load data from W
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd5; alu_res_m = 32'h777; src1 = 5'd5; rf1 = 32'h5;
      step("lu_stall", 32'h0, 32'h5, 2'd0, 2'd0, 1'b1);
      idle(); wr_en_w = 1'b1; is_load_w = 1'b1; rd_w = 5'd5; alu_res_w = 32'h777;
      mem_rdata_w = 32'hDEAD_BEEF; src1 = 5'd5;
      step("lu_wfwd", 32'h0, 32'hDEAD_BEEF, 2'd0, 2'd2, 1'b0);

      // history forward one cycle after W
      idle(); wr_en_w = 1'b1; rd_w = 5'd7; alu_res_w = 32'h11; mem_rdata_w = 32'h55;
      step("hist_wr", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
      idle(); src0 = 5'd7; src1 = 5'd5; rf1 = 32'h2;
      step("hist_fwd", 32'h11, 32'h2, 2'd3, 2'd0, 1'b0);

      // register 0 never forwards or stalls
      idle(); wr_en_m = 1'b1; rd_m = 5'd0; alu_res_m = 32'h5;
      wr_en_w = 1'b1; is_load_w = 1'b1; rd_w = 5'd0; mem_rdata_w = 32'h66;
      step("r0_mw", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd0;
      step("r0_ld_hist", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);

      // priority M > W > history
      idle(); wr_en_w = 1'b1; rd_w = 5'd4; alu_res_w = 32'hC;
      step("prio_seed", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
      idle(); wr_en_m = 1'b1; rd_m = 5'd4; alu_res_m = 32'hA;
      wr_en_w = 1'b1; rd_w = 5'd4; alu_res_w = 32'hB; src0 = 5'd4; src1 = 5'd4;
      step("prio_m", 32'hA, 32'hA, 2'd1, 2'd1, 1'b0);
      idle(); wr_en_w = 1'b1; rd_w = 5'd4; alu_res_w = 32'hD; src0 = 5'd4; src1 = 5'd4;
      step("prio_w", 32'hD, 32'hD, 2'd2, 2'd2, 1'b0);
      // load-use hit still shows lower-priority (history) match
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd4; alu_res_m = 32'h999;
      src0 = 5'd4; src1 = 5'd4; rf1 = 32'h7;
      step("lu_hist", 32'hD, 32'hD, 2'd3, 2'd3, 1'b1);
      idle(); src0 = 5'd4;
      step("hist_aged", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);

      // freeze holds history and suppresses stall
      idle(); wr_en_w = 1'b1; rd_w = 5'd9; alu_res_w = 32'h99;
      step("frz_seed", 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
      idle(); freeze_i = 1'b1; wr_en_w = 1'b1; rd_w = 5'd9; alu_res_w = 32'hAA; src0 = 5'd9;
      step("frz1", 32'hAA, 32'h0, 2'd2, 2'd0, 1'b0);
      idle(); freeze_i = 1'b1; wr_en_w = 1'b1; rd_w = 5'd9; alu_res_w = 32'hBB;
      wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd9; src0 = 5'd9;
      step("frz2_nostall", 32'hBB, 32'h0, 2'd2, 2'd0, 1'b0);
      idle(); freeze_i = 1'b1; wr_en_w = 1'b1; rd_w = 5'd10; alu_res_w = 32'hCC;
      src0 = 5'd9; src1 = 5'd10;
      step("frz3", 32'h99, 32'hCC, 2'd3, 2'd2, 1'b0);
      idle(); src0 = 5'd9;
      step("frz_after", 32'h99, 32'h0, 2'd3, 2'd0, 1'b0);

      // reset asserted during back-to-back stall
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd2; src0 = 5'd2; rf0 = 32'h21;
      wr_en_w = 1'b1; rd_w = 5'd6; alu_res_w = 32'h66;
      step("stall1", 32'h21, 32'h0, 2'd0, 2'd0, 1'b1);
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd2; src0 = 5'd2; rf0 = 32'h21;
      wr_en_w = 1'b1; rd_w = 5'd6; alu_res_w = 32'h67; src1 = 5'd6; rf1 = 32'h3;
      step("stall2", 32'h21, 32'h67, 2'd0, 2'd2, 1'b1);
      idle(); wr_en_m = 1'b1; is_load_m = 1'b1; rd_m = 5'd2; src0 = 5'd2; rf0 = 32'h21;
      src1 = 5'd6; rf1 = 32'h3;
      rst = 1'b1;
      step("rst_stall", 32'h21, 32'h3, 2'd0, 2'd0, 1'b0);
      rst = 1'b0;
      idle(); src0 = 5'd2; rf0 = 32'h21; src1 = 5'd6; rf1 = 32'h3;
      step("post_rst", 32'h21, 32'h3, 2'd0, 2'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
